commit_unit: RTL and testbench

//  In-order retirement engine at the read end of the reorder buffer. It inspects the ROB head each cycle
//  and pops finished entries. Each retire drives the retirement RAT, the free list and the branch predictor.

---
 rtl/commit_unit.sv | 215 +++++++++++++++++++++
 tb/tb_commit_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
//
// In-order retirement engine sitting at the read end of the reorder buffer.
// Each cycle it looks at the ROB head and retires at most one finished entry.
//
// A non-store retire pops the head in the same cycle. On the following edge it
// produces these single-cycle effects:
//   - a free-list release and a retirement-RAT write (when rd_arch != 0)
//   - a branch-predictor training pulse (when the entry is a branch)
//   - a pipeline flush with the redirect PC (when the branch mispredicted)
//
// A store is first offered to the store buffer over a valid/ready handshake.
// It is popped only on the cycle the store buffer accepts it.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   head_*                 ROB head entry fields (valid, finish, type, regs,
//                          store id, branch resolution)
//   rob_pop                combinational head advance
//   st_commit_valid/id     store commit request (registered)
//   st_commit_ready        store buffer accepts the commit
//   free_valid/free_phy    release of the previous physical mapping
//   rrat_we/arch/phy       retirement RAT write port
//   bp_update_*            predictor training pulse with pc/taken/target
//   flush/redirect_pc      one-cycle pipeline flush and fetch restart PC
//   retire_count           wrapping count of retired instructions
// -----------------------------------------------------------------------------
module commit_unit #(
   parameter int ROB_WIDTH  = 4,
   parameter int PHY_WIDTH  = 6,
   parameter int ARCH_WIDTH = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int SID_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  head_valid,
   input  logic                  head_finish,
   input  logic                  head_has_rd,
   input  logic                  head_is_store,
   input  logic                  head_is_branch,
   input  logic [ARCH_WIDTH-1:0] head_rd_arch,
   input  logic [PHY_WIDTH-1:0]  head_rd_phy_old,
   input  logic [PHY_WIDTH-1:0]  head_rd_phy_new,
   input  logic [SID_WIDTH-1:0]  head_store_id,
   input  logic                  head_mispredict,
   input  logic                  head_actual_taken,
   input  logic [ADDR_WIDTH-1:0] head_actual_target,
   input  logic [ADDR_WIDTH-1:0] head_update_pc,
   output logic                  rob_pop,
   output logic                  st_commit_valid,
   output logic [SID_WIDTH-1:0]  st_commit_id,
   input  logic                  st_commit_ready,
   output logic                  free_valid,
   output logic [PHY_WIDTH-1:0]  free_phy,
   output logic                  rrat_we,
   output logic [ARCH_WIDTH-1:0] rrat_arch,
   output logic [PHY_WIDTH-1:0]  rrat_phy,
   output logic                  bp_update_valid,
   output logic [ADDR_WIDTH-1:0] bp_update_pc,
   output logic                  bp_update_taken,
   output logic [ADDR_WIDTH-1:0] bp_update_target,
   output logic                  flush,
   output logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [31:0]           retire_count
);

   if (ROB_WIDTH < 1 || PHY_WIDTH < 1 || ARCH_WIDTH < 1 ||
       ADDR_WIDTH < 3 || SID_WIDTH < 1) begin : g_param_check
      $error("commit_unit: illegal width parameter");
   end

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      STORE_WAIT = 2'd1,
      FLUSH      = 2'd2
   } state_t;

   // Fetch restart address: the resolved target if taken, otherwise the
   // fall-through PC. The addition wraps modulo 2^ADDR_WIDTH.
   function automatic logic [ADDR_WIDTH-1:0] redirect_target(
      input logic                  taken,
      input logic [ADDR_WIDTH-1:0] target,
      input logic [ADDR_WIDTH-1:0] pc
   );
      return taken ? target : pc + ADDR_WIDTH'(4);
   endfunction

   state_t                  state_q;
   logic                    st_commit_valid_q;
   logic [SID_WIDTH-1:0]    st_commit_id_q;
   logic                    free_valid_q;
   logic [PHY_WIDTH-1:0]    free_phy_q;
   logic                    rrat_we_q;
   logic [ARCH_WIDTH-1:0]   rrat_arch_q;
   logic [PHY_WIDTH-1:0]    rrat_phy_q;
   logic                    bp_update_valid_q;
   logic [ADDR_WIDTH-1:0]   bp_update_pc_q;
   logic                    bp_update_taken_q;
   logic [ADDR_WIDTH-1:0]   bp_update_target_q;
   logic                    flush_q;
   logic [ADDR_WIDTH-1:0]   redirect_pc_q;
   logic [31:0]             retire_count_q;
   logic [31:0]             retire_count_d;

   logic head_done;
   logic run_retire;
   logic store_accept;
   logic rd_writes;

   assign head_done      = head_valid & head_finish;
   assign run_retire     = (state_q == RUN) & head_done & ~head_is_store;
   assign store_accept   = (state_q == STORE_WAIT) & st_commit_ready;
   // x0 is hard-wired: retiring a write to it neither frees nor remaps.
   assign rd_writes      = head_has_rd & (head_rd_arch != '0);
   assign retire_count_d = retire_count_q + 32'd1;

   // The pop is combinational. It is gated by rst so that nothing escapes
   // while reset is held, even with a finished head on the inputs.
   assign rob_pop = ~rst & (run_retire | store_accept);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q            <= RUN;
         st_commit_valid_q  <= 1'b0;
         st_commit_id_q     <= '0;
         free_valid_q       <= 1'b0;
         free_phy_q         <= '0;
         rrat_we_q          <= 1'b0;
         rrat_arch_q        <= '0;
         rrat_phy_q         <= '0;
         bp_update_valid_q  <= 1'b0;
         bp_update_pc_q     <= '0;
         bp_update_taken_q  <= 1'b0;
         bp_update_target_q <= '0;
         flush_q            <= 1'b0;
         redirect_pc_q      <= '0;
         retire_count_q     <= '0;
      end else begin
         // Side-effect strobes are single-cycle pulses by default.
         free_valid_q      <= 1'b0;
         rrat_we_q         <= 1'b0;
         bp_update_valid_q <= 1'b0;
         flush_q           <= 1'b0;

         unique case (state_q)
            RUN: begin
               if (head_done && !head_is_store) begin
                  retire_count_q <= retire_count_d;
                  if (rd_writes) begin
                     free_valid_q <= 1'b1;
                     free_phy_q   <= head_rd_phy_old;
                     rrat_we_q    <= 1'b1;
                     rrat_arch_q  <= head_rd_arch;
                     rrat_phy_q   <= head_rd_phy_new;
                  end
                  if (head_is_branch) begin
                     bp_update_valid_q  <= 1'b1;
                     bp_update_pc_q     <= head_update_pc;
                     bp_update_taken_q  <= head_actual_taken;
                     bp_update_target_q <= head_actual_target;
                  end
                  if (head_is_branch && head_mispredict) begin
                     flush_q       <= 1'b1;
                     redirect_pc_q <= redirect_target(head_actual_taken,
                                                      head_actual_target,
                                                      head_update_pc);
                     state_q       <= FLUSH;
                  end
               end else if (head_done && head_is_store) begin
                  st_commit_valid_q <= 1'b1;
                  st_commit_id_q    <= head_store_id;
                  state_q           <= STORE_WAIT;
               end
            end

            STORE_WAIT: begin
               // Request stays stable until the store buffer takes it; the
               // store then counts as retired.
               if (st_commit_ready) begin
                  st_commit_valid_q <= 1'b0;
                  retire_count_q    <= retire_count_d;
                  state_q           <= RUN;
               end
            end

            FLUSH: begin
               // Head contents are stale during the flush cycle and are ignored.
               state_q <= RUN;
            end

            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   assign st_commit_valid  = st_commit_valid_q;
   assign st_commit_id     = st_commit_id_q;
   assign free_valid       = free_valid_q;
   assign free_phy         = free_phy_q;
   assign rrat_we          = rrat_we_q;
   assign rrat_arch        = rrat_arch_q;
   assign rrat_phy         = rrat_phy_q;
   assign bp_update_valid  = bp_update_valid_q;
   assign bp_update_pc     = bp_update_pc_q;
   assign bp_update_taken  = bp_update_taken_q;
   assign bp_update_target = bp_update_target_q;
   assign flush            = flush_q;
   assign redirect_pc      = redirect_pc_q;
   assign retire_count     = retire_count_q;

endmodule

// File: tb/tb_commit_unit.sv
// -----------------------------------------------------------------------------
// tb_commit_unit
//
// Drives commit_unit from a queue standing in for the reorder buffer and
// checks every output against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_commit_unit;

   localparam int PW = 6;
   localparam int AW = 5;
   localparam int XW = 32;
   localparam int SW = 4;

   typedef struct {
      bit          fin;
      bit          has_rd;
      bit          is_store;
      bit          is_branch;
      bit [AW-1:0] arch;
      bit [PW-1:0] phy_old;
      bit [PW-1:0] phy_new;
      bit [SW-1:0] sid;
      bit          mis;
      bit          taken;
      bit [XW-1:0] target;
      bit [XW-1:0] pc;
   } instr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          head_valid, head_finish, head_has_rd, head_is_store, head_is_branch;
   logic [AW-1:0] head_rd_arch;
   logic [PW-1:0] head_rd_phy_old, head_rd_phy_new;
   logic [SW-1:0] head_store_id;
   logic          head_mispredict, head_actual_taken;
   logic [XW-1:0] head_actual_target, head_update_pc;
   logic          rob_pop, st_commit_valid, st_commit_ready;
   logic [SW-1:0] st_commit_id;
   logic          free_valid, rrat_we, bp_update_valid, bp_update_taken, flush;
   logic [PW-1:0] free_phy, rrat_phy;
   logic [AW-1:0] rrat_arch;
   logic [XW-1:0] bp_update_pc, bp_update_target, redirect_pc;
   logic [31:0]   retire_count;

   commit_unit #(
      .ROB_WIDTH(4), .PHY_WIDTH(PW), .ARCH_WIDTH(AW), .ADDR_WIDTH(XW), .SID_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst),
      .head_valid(head_valid), .head_finish(head_finish), .head_has_rd(head_has_rd),
      .head_is_store(head_is_store), .head_is_branch(head_is_branch),
      .head_rd_arch(head_rd_arch), .head_rd_phy_old(head_rd_phy_old),
      .head_rd_phy_new(head_rd_phy_new), .head_store_id(head_store_id),
      .head_mispredict(head_mispredict), .head_actual_taken(head_actual_taken),
      .head_actual_target(head_actual_target), .head_update_pc(head_update_pc),
      .rob_pop(rob_pop), .st_commit_valid(st_commit_valid), .st_commit_id(st_commit_id),
      .st_commit_ready(st_commit_ready), .free_valid(free_valid), .free_phy(free_phy),
      .rrat_we(rrat_we), .rrat_arch(rrat_arch), .rrat_phy(rrat_phy),
      .bp_update_valid(bp_update_valid), .bp_update_pc(bp_update_pc),
      .bp_update_taken(bp_update_taken), .bp_update_target(bp_update_target),
      .flush(flush), .redirect_pc(redirect_pc), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int pop_seen = 0;
   bit rand_mode = 0;

   instr_t rob[$];

   // Reference model: what the outputs must show in the current cycle.
   bit          m_flush_now;   // this cycle is the flush cycle after a mispredict
   bit          m_store_wait;  // a store has been offered and not yet accepted
   bit          e_st_valid;
   bit [SW-1:0] e_st_id;
   bit          e_free_valid;
   bit [PW-1:0] e_free_phy;
   bit          e_rrat_we;
   bit [AW-1:0] e_rrat_arch;
   bit [PW-1:0] e_rrat_phy;
   bit          e_bp_valid;
   bit [XW-1:0] e_bp_pc;
   bit          e_bp_taken;
   bit [XW-1:0] e_bp_target;
   bit          e_flush;
   bit [XW-1:0] e_redirect;
   longint      e_count;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_flush_now = 0; m_store_wait = 0;
      e_st_valid = 0; e_st_id = '0;
      e_free_valid = 0; e_free_phy = '0;
      e_rrat_we = 0; e_rrat_arch = '0; e_rrat_phy = '0;
      e_bp_valid = 0; e_bp_pc = '0; e_bp_taken = 0; e_bp_target = '0;
      e_flush = 0; e_redirect = '0; e_count = 0;
   endtask

   function automatic instr_t mk(bit fin, bit has_rd, bit st, bit br, int arch, int po, int pn,
                                 int sid, bit mis, bit tk, bit [XW-1:0] tgt, bit [XW-1:0] pc);
      instr_t t;
      t.fin = fin; t.has_rd = has_rd; t.is_store = st; t.is_branch = br;
      t.arch = AW'(arch); t.phy_old = PW'(po); t.phy_new = PW'(pn); t.sid = SW'(sid);
      t.mis = mis; t.taken = tk; t.target = tgt; t.pc = pc;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      int k;
      k = int'($urandom_range(0, 9));
      t.fin       = ($urandom_range(0, 3) == 0);
      t.is_store  = (k < 2);
      t.is_branch = (k >= 2 && k < 5);
      t.has_rd    = ($urandom_range(0, 4) != 0);
      t.arch      = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
      t.phy_old   = PW'($urandom);
      t.phy_new   = PW'($urandom);
      t.sid       = SW'($urandom);
      t.mis       = ($urandom_range(0, 2) == 0);
      t.taken     = 1'($urandom);
      t.target    = $urandom;
      t.pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom;
      return t;
   endfunction

   task automatic drive_head();
      if (rob.size() > 0) begin
         head_valid         = 1'b1;
         head_finish        = rob[0].fin;
         head_has_rd        = rob[0].has_rd;
         head_is_store      = rob[0].is_store;
         head_is_branch     = rob[0].is_branch;
         head_rd_arch       = rob[0].arch;
         head_rd_phy_old    = rob[0].phy_old;
         head_rd_phy_new    = rob[0].phy_new;
         head_store_id      = rob[0].sid;
         head_mispredict    = rob[0].mis;
         head_actual_taken  = rob[0].taken;
         head_actual_target = rob[0].target;
         head_update_pc     = rob[0].pc;
      end else begin
         // Empty ROB: the other head fields are garbage and must be ignored.
         head_valid         = 1'b0;
         head_finish        = 1'($urandom);
         head_has_rd        = 1'($urandom);
         head_is_store      = 1'($urandom);
         head_is_branch     = 1'($urandom);
         head_rd_arch       = AW'($urandom);
         head_rd_phy_old    = PW'($urandom);
         head_rd_phy_new    = PW'($urandom);
         head_store_id      = SW'($urandom);
         head_mispredict    = 1'($urandom);
         head_actual_taken  = 1'($urandom);
         head_actual_target = $urandom;
         head_update_pc     = $urandom;
      end
   endtask

   // Compare the current cycle, then advance the model across the next edge.
   task automatic evaluate();
      instr_t h;
      bit     hv;
      bit     e_pop;
      hv = (rob.size() > 0);
      h  = hv ? rob[0] : mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, '0, '0);

      if (m_flush_now)       e_pop = 0;
      else if (m_store_wait) e_pop = st_commit_ready;
      else                   e_pop = hv && h.fin && !h.is_store;

      if (rob_pop === 1'b1) pop_seen++;
      check("rob_pop", 64'(rob_pop), 64'(e_pop));
      check("st_commit_valid", 64'(st_commit_valid), 64'(e_st_valid));
      if (e_st_valid) check("st_commit_id", 64'(st_commit_id), 64'(e_st_id));
      check("free_valid", 64'(free_valid), 64'(e_free_valid));
      if (e_free_valid) check("free_phy", 64'(free_phy), 64'(e_free_phy));
      check("rrat_we", 64'(rrat_we), 64'(e_rrat_we));
      if (e_rrat_we) begin
         check("rrat_arch", 64'(rrat_arch), 64'(e_rrat_arch));
         check("rrat_phy", 64'(rrat_phy), 64'(e_rrat_phy));
      end
      check("bp_update_valid", 64'(bp_update_valid), 64'(e_bp_valid));
      if (e_bp_valid) begin
         check("bp_update_pc", 64'(bp_update_pc), 64'(e_bp_pc));
         check("bp_update_taken", 64'(bp_update_taken), 64'(e_bp_taken));
         check("bp_update_target", 64'(bp_update_target), 64'(e_bp_target));
      end
      check("flush", 64'(flush), 64'(e_flush));
      if (e_flush) check("redirect_pc", 64'(redirect_pc), 64'(e_redirect));
      check("retire_count", 64'(retire_count), 64'(e_count));

      e_free_valid = 0; e_rrat_we = 0; e_bp_valid = 0; e_flush = 0;
      if (m_flush_now) begin
         m_flush_now = 0;
      end else if (m_store_wait) begin
         if (st_commit_ready) begin
            m_store_wait = 0; e_st_valid = 0;
            e_count = (e_count + 1) % 64'h1_0000_0000;
            void'(rob.pop_front());
         end
      end else if (hv && h.fin) begin
         if (h.is_store) begin
            m_store_wait = 1; e_st_valid = 1; e_st_id = h.sid;
         end else begin
            e_count = (e_count + 1) % 64'h1_0000_0000;
            void'(rob.pop_front());
            if (h.has_rd && h.arch != 0) begin
               e_free_valid = 1; e_free_phy = h.phy_old;
               e_rrat_we = 1; e_rrat_arch = h.arch; e_rrat_phy = h.phy_new;
            end
            if (h.is_branch) begin
               e_bp_valid = 1; e_bp_pc = h.pc; e_bp_taken = h.taken; e_bp_target = h.target;
               if (h.mis) begin
                  e_flush = 1; m_flush_now = 1;
                  e_redirect = h.taken ? h.target
                                       : XW'((longint'(h.pc) + 4) % 64'h1_0000_0000);
               end
            end
         end
      end
   endtask

   task automatic step(input bit rdy);
      instr_t t;
      @(negedge clk);
      if (rand_mode) begin
         if (rob.size() < 4 && $urandom_range(0, 1) == 1) rob.push_back(rand_instr());
         if (rob.size() > 0 && !rob[0].fin && $urandom_range(0, 1) == 1) begin
            t = rob[0]; t.fin = 1; rob[0] = t;
         end
         st_commit_ready = ($urandom_range(0, 2) == 0);
      end else begin
         st_commit_ready = rdy;
      end
      drive_head();
      #1;
      evaluate();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rob_pop"}, 64'(rob_pop), 64'd0);
      check({tag, "_st_valid"}, 64'(st_commit_valid), 64'd0);
      check({tag, "_st_id"}, 64'(st_commit_id), 64'd0);
      check({tag, "_free_valid"}, 64'(free_valid), 64'd0);
      check({tag, "_free_phy"}, 64'(free_phy), 64'd0);
      check({tag, "_rrat_we"}, 64'(rrat_we), 64'd0);
      check({tag, "_rrat_arch"}, 64'(rrat_arch), 64'd0);
      check({tag, "_rrat_phy"}, 64'(rrat_phy), 64'd0);
      check({tag, "_bp_valid"}, 64'(bp_update_valid), 64'd0);
      check({tag, "_bp_pc"}, 64'(bp_update_pc), 64'd0);
      check({tag, "_bp_taken"}, 64'(bp_update_taken), 64'd0);
      check({tag, "_bp_target"}, 64'(bp_update_target), 64'd0);
      check({tag, "_flush"}, 64'(flush), 64'd0);
      check({tag, "_redirect"}, 64'(redirect_pc), 64'd0);
      check({tag, "_retire_count"}, 64'(retire_count), 64'd0);
   endtask

   initial begin
      int p0;
      instr_t t;
      rst = 1'b1;
      st_commit_ready = 1'b0;
      drive_head();
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_all_zero("por");
      @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a store handshake.
      rob.push_back(mk(1, 0, 1, 0, 0, 0, 0, 7, 0, 0, '0, '0));
      step(0);
      step(0);
      @(negedge clk);
      st_commit_ready = 1'b1;
      #1 check("store_pop_before_rst", 64'(rob_pop), 64'd1);
      #1 rst = 1'b1;
      #1 check_all_zero("rst_mid_store");
      @(negedge clk);
      rst = 1'b0;
      st_commit_ready = 1'b0;
      rob.delete();
      model_reset();
      drive_head();

      // Finished ALU op right after reset: pops at once, so the FSM is in RUN.
      rob.push_back(mk(1, 1, 0, 0, 3, 10, 20, 0, 0, 0, '0, '0));
      step(0);
      check("alu_pop_same_cycle", 64'(rob_pop), 64'd1);
      step(0);
      check("alu_free_phy", 64'(free_phy), 64'd10);
      check("alu_rrat_arch", 64'(rrat_arch), 64'd3);
      check("alu_rrat_phy", 64'(rrat_phy), 64'd20);
      check("alu_retire_count", 64'(retire_count), 64'd1);

      // Unfinished head for 5 cycles.
      rob.push_back(mk(0, 1, 0, 0, 5, 11, 21, 0, 0, 0, '0, '0));
      p0 = pop_seen;
      repeat (5) step(0);
      check("unfinished_no_pop", 64'(pop_seen - p0), 64'd0);
      t = rob[0]; t.fin = 1; rob[0] = t;
      step(0);

      // Store sid=7 with the store buffer ready on the third request cycle.
      rob.push_back(mk(1, 1, 1, 0, 9, 12, 22, 7, 0, 0, '0, '0));
      p0 = pop_seen;
      step(0);
      step(0);
      step(0);
      step(1);
      check("store_single_pop", 64'(pop_seen - p0), 64'd1);
      step(0);

      // Taken mispredict followed by a finished head that must wait one cycle.
      rob.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h100, 32'h80));
      rob.push_back(mk(1, 1, 0, 0, 7, 13, 23, 0, 0, 0, '0, '0));
      step(0);
      step(0);
      check("mis_taken_flush", 64'(flush), 64'd1);
      check("mis_taken_redirect", 64'(redirect_pc), 64'h100);
      check("mis_flush_no_pop", 64'(rob_pop), 64'd0);
      step(0);
      rob.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h200, 32'h40));
      step(0);
      step(0);
      check("mis_not_taken_redirect", 64'(redirect_pc), 64'h44);
      rob.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h200, 32'hFFFF_FFFC));
      step(0);
      step(0);
      check("mis_pc_wrap_redirect", 64'(redirect_pc), 64'h0);
      step(0);

      // Retire to x0, then four finished heads back to back.
      rob.push_back(mk(1, 1, 0, 0, 0, 14, 24, 0, 0, 0, '0, '0));
      step(0);
      step(0);
      check("x0_no_free", 64'(free_valid), 64'd0);
      check("x0_no_rrat", 64'(rrat_we), 64'd0);
      for (int i = 0; i < 4; i++) rob.push_back(mk(1, 1, 0, 0, i + 1, i + 30, i + 40, 0, 0, 0, '0, '0));
      p0 = pop_seen;
      repeat (4) step(0);
      check("back_to_back_pops", 64'(pop_seen - p0), 64'd4);
      step(0);

      // Randomized traffic.
      rand_mode = 1;
      repeat (3000) step(0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
